// File: rtl/vram_arbiter.sv
// Arbiter for the shared 1024x9 video/work RAM between the CPU data port and the VGA
// character-fetch engine: fixed CPU priority, video anti-starvation, registered RAM port.
module vram_arbiter #(
    parameter int unsigned VID_STARVE_LIMIT = 3,
    parameter int unsigned STALL_CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [9:0]             cpu_addr,
    input  logic [8:0]             cpu_wdata,
    output logic [7:0]             cpu_rdata,
    output logic                   cpu_done,
    output logic                   cpu_ovf,
    input  logic                   vid_req,
    input  logic [8:0]             vid_addr,
    output logic [8:0]             vid_rdata,
    output logic                   vid_ack,
    output logic                   ram_en,
    output logic                   ram_we,
    output logic [9:0]             ram_addr,
    output logic [8:0]             ram_wdata,
    input  logic [8:0]             ram_rdata,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    localparam logic [2:0] StarveLimit = 3'(VID_STARVE_LIMIT);

    logic                   cpu_pend_q, cpu_pend_d;
    logic                   cpu_we_q, cpu_we_d;
    logic [9:0]             cpu_addr_q, cpu_addr_d;
    logic [8:0]             cpu_wdata_q, cpu_wdata_d;
    logic                   cpu_ovf_q, cpu_ovf_d;
    logic                   vid_pend_q, vid_pend_d;
    logic [8:0]             vid_addr_q, vid_addr_d;
    logic [2:0]             vid_wait_q, vid_wait_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                   ram_en_q, ram_en_d;
    logic                   ram_we_q, ram_we_d;
    logic [9:0]             ram_addr_q, ram_addr_d;
    logic [8:0]             ram_wdata_q, ram_wdata_d;
    logic                   tag1_valid_q, tag1_vid_q;
    logic                   tag2_valid_q, tag2_vid_q;
    logic                   cpu_done_q, vid_ack_q;
    logic [7:0]             cpu_rdata_q;
    logic [8:0]             vid_rdata_q;

    logic       eff_cpu, eff_vid, grant_cpu, grant_vid;
    logic       sel_we;
    logic [9:0] sel_addr;
    logic [8:0] sel_wdata;
    logic [8:0] sel_vaddr;

    // An already-pending CPU request is served before a newly arriving strobe; the
    // video strobe always carries the latest address.
    always_comb begin
        eff_cpu   = cpu_pend_q | cpu_req;
        eff_vid   = vid_pend_q | vid_req;
        grant_vid = eff_vid & (~eff_cpu | (vid_wait_q >= StarveLimit));
        grant_cpu = eff_cpu & ~grant_vid;
        sel_we    = cpu_pend_q ? cpu_we_q    : cpu_we;
        sel_addr  = cpu_pend_q ? cpu_addr_q  : cpu_addr;
        sel_wdata = cpu_pend_q ? cpu_wdata_q : cpu_wdata;
        sel_vaddr = vid_req    ? vid_addr    : vid_addr_q;
    end

    always_comb begin
        cpu_pend_d  = cpu_pend_q;
        cpu_we_d    = cpu_we_q;
        cpu_addr_d  = cpu_addr_q;
        cpu_wdata_d = cpu_wdata_q;
        if (cpu_req && (cpu_pend_q || !grant_cpu)) begin
            cpu_pend_d  = 1'b1;
            cpu_we_d    = cpu_we;
            cpu_addr_d  = cpu_addr;
            cpu_wdata_d = cpu_wdata;
        end else if (grant_cpu) begin
            cpu_pend_d = 1'b0;
        end
        cpu_ovf_d = cpu_ovf_q | (cpu_req & cpu_pend_q & ~grant_cpu);

        vid_pend_d = vid_pend_q;
        vid_addr_d = vid_addr_q;
        if (grant_vid) begin
            vid_pend_d = 1'b0;
        end else if (vid_req) begin
            vid_pend_d = 1'b1;
            vid_addr_d = vid_addr;
        end

        if (eff_vid && !grant_vid) begin
            vid_wait_d = (vid_wait_q == 3'd7) ? vid_wait_q : vid_wait_q + 3'd1;
        end else begin
            vid_wait_d = '0;
        end

        stall_cnt_d = stall_cnt_q;
        if (((eff_cpu & ~grant_cpu) | (eff_vid & ~grant_vid)) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end

        ram_en_d    = grant_cpu | grant_vid;
        ram_we_d    = grant_cpu & sel_we;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if (grant_cpu) begin
            ram_addr_d  = sel_addr;
            ram_wdata_d = sel_wdata;
        end else if (grant_vid) begin
            ram_addr_d = {1'b1, sel_vaddr};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_pend_q   <= 1'b0;
            cpu_we_q     <= 1'b0;
            cpu_addr_q   <= '0;
            cpu_wdata_q  <= '0;
            cpu_ovf_q    <= 1'b0;
            vid_pend_q   <= 1'b0;
            vid_addr_q   <= '0;
            vid_wait_q   <= '0;
            stall_cnt_q  <= '0;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            tag1_valid_q <= 1'b0;
            tag1_vid_q   <= 1'b0;
            tag2_valid_q <= 1'b0;
            tag2_vid_q   <= 1'b0;
            cpu_done_q   <= 1'b0;
            vid_ack_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            vid_rdata_q  <= '0;
        end else begin
            cpu_pend_q   <= cpu_pend_d;
            cpu_we_q     <= cpu_we_d;
            cpu_addr_q   <= cpu_addr_d;
            cpu_wdata_q  <= cpu_wdata_d;
            cpu_ovf_q    <= cpu_ovf_d;
            vid_pend_q   <= vid_pend_d;
            vid_addr_q   <= vid_addr_d;
            vid_wait_q   <= vid_wait_d;
            stall_cnt_q  <= stall_cnt_d;
            ram_en_q     <= ram_en_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            // Owner tag follows the access: stage 1 with ram_en, stage 2 with ram_rdata.
            tag1_valid_q <= ram_en_d;
            tag1_vid_q   <= grant_vid;
            tag2_valid_q <= tag1_valid_q;
            tag2_vid_q   <= tag1_vid_q;
            cpu_done_q   <= tag2_valid_q & ~tag2_vid_q;
            vid_ack_q    <= tag2_valid_q & tag2_vid_q;
            if (tag2_valid_q && !tag2_vid_q) begin
                cpu_rdata_q <= ram_rdata[7:0];
            end
            if (tag2_valid_q && tag2_vid_q) begin
                vid_rdata_q <= ram_rdata;
            end
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_done  = cpu_done_q;
    assign cpu_ovf   = cpu_ovf_q;
    assign vid_rdata = vid_rdata_q;
    assign vid_ack   = vid_ack_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level model with a shadow memory.
module tb_vram_arbiter;
    localparam int SW    = 4;
    localparam int LIMIT = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [9:0]    cpu_addr = '0;
    logic [8:0]    cpu_wdata = '0;
    logic [7:0]    cpu_rdata;
    logic          cpu_done, cpu_ovf;
    logic          vid_req = 1'b0;
    logic [8:0]    vid_addr = '0;
    logic [8:0]    vid_rdata;
    logic          vid_ack;
    logic          ram_en, ram_we;
    logic [9:0]    ram_addr;
    logic [8:0]    ram_wdata;
    logic [8:0]    ram_rdata;
    logic [SW-1:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    vram_arbiter #(.VID_STARVE_LIMIT(LIMIT), .STALL_CNT_W(SW)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_ovf(cpu_ovf),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_ack(vid_ack),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Single-port RAM macro with a 1-cycle registered read.
    logic [8:0] mem [1024];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (transaction level) ----------------
    typedef struct {
        int         due;
        bit         is_vid;
        bit         is_wr;
        bit         ok;
        logic [8:0] data;
    } ev_t;

    ev_t        evq[$];
    logic [8:0] shadow [1024];
    bit         shadow_ok [1024];
    int         mc_cyc;
    bit         m_cpu_pend, m_cwe, m_vid_pend, m_ovf;
    logic [9:0] m_ca;
    logic [8:0] m_cw, m_va;
    int         m_wait, m_stall;
    bit         e_en, e_we, e_cdone, e_vack, e_crd_ok, e_vrd_ok;
    logic [9:0] e_addr;
    logic [8:0] e_wdata, e_vrd;
    logic [7:0] e_crd;

    task automatic model_reset();
        evq.delete();
        mc_cyc = 0;
        m_cpu_pend = 0; m_cwe = 0; m_vid_pend = 0; m_ovf = 0;
        m_ca = '0; m_cw = '0; m_va = '0; m_wait = 0; m_stall = 0;
        e_en = 0; e_we = 0; e_cdone = 0; e_vack = 0;
        e_addr = '0; e_wdata = '0; e_crd = '0; e_vrd = '0;
        e_crd_ok = 1; e_vrd_ok = 1;
        for (int i = 0; i < 1024; i++) shadow_ok[i] = 0;
    endtask

    // One clock edge of the arbitration rules, applied to the inputs sampled at that edge.
    task automatic model_step();
        bit         ec, ev, gc, gv, we;
        logic [9:0] ca, va;
        logic [8:0] cw;
        ev_t        e;
        ec = m_cpu_pend || cpu_req;
        ev = m_vid_pend || vid_req;
        gv = ev && (!ec || m_wait >= LIMIT);
        gc = ec && !gv;
        we = m_cpu_pend ? m_cwe : cpu_we;
        ca = m_cpu_pend ? m_ca  : cpu_addr;
        cw = m_cpu_pend ? m_cw  : cpu_wdata;
        va = {1'b1, (vid_req ? vid_addr : m_va)};
        if (((ec && !gc) || (ev && !gv)) && m_stall < (1 << SW) - 1) m_stall++;
        m_wait = (ev && !gv) ? ((m_wait < 7) ? m_wait + 1 : 7) : 0;
        if (cpu_req && m_cpu_pend && !gc) m_ovf = 1;
        e_en = gc || gv;
        e_we = gc && we;
        if (gc || gv) begin
            e.due    = mc_cyc + 3;
            e.is_vid = gv;
            e.is_wr  = gc && we;
            e.ok     = gv ? shadow_ok[va] : shadow_ok[ca];
            e.data   = gv ? shadow[va] : shadow[ca];
            evq.push_back(e);
            e_addr = gv ? va : ca;
            if (gc) e_wdata = cw;
            if (gc && we) begin
                shadow[ca] = cw;
                shadow_ok[ca] = 1;
            end
        end
        if (cpu_req && (m_cpu_pend || !gc)) begin
            m_cpu_pend = 1; m_cwe = cpu_we; m_ca = cpu_addr; m_cw = cpu_wdata;
        end else if (gc) begin
            m_cpu_pend = 0;
        end
        if (gv) m_vid_pend = 0;
        else if (vid_req) begin
            m_vid_pend = 1; m_va = vid_addr;
        end
        mc_cyc++;
        e_cdone = 0;
        e_vack = 0;
        while (evq.size() > 0 && evq[0].due == mc_cyc) begin
            e = evq.pop_front();
            if (e.is_vid) begin
                e_vack = 1; e_vrd = e.data; e_vrd_ok = e.ok;
            end else begin
                e_cdone = 1; e_crd = e.data[7:0]; e_crd_ok = e.ok && !e.is_wr;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; vid_req = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 0;
        idle_inputs();
        @(negedge clk);
        reset_n = 1;
    endtask

    task automatic cpu_write_drain(input logic [9:0] a, input logic [8:0] d);
        @(negedge clk);
        cpu_req = 1; cpu_we = 1; cpu_addr = a; cpu_wdata = d;
        @(negedge clk);
        idle_inputs();
        repeat (4) @(negedge clk);
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        reset_n = 0;
        idle_inputs();
        repeat (2) @(negedge clk);
        checks++;
        if ({cpu_rdata, cpu_done, cpu_ovf, vid_rdata, vid_ack, ram_en, ram_we, ram_addr,
             ram_wdata, stall_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got en=%b addr=%h stall=%0d done=%b, expected all 0",
                     ram_en, ram_addr, stall_cnt, cpu_done);
        end
        reset_n = 1;
        @(negedge clk);
        checks++;
        if ({ram_en, stall_cnt, cpu_ovf} !== '0) begin
            errors++;
            $display("FAIL reset_idle: got en=%b stall=%0d ovf=%b, expected 0", ram_en,
                     stall_cnt, cpu_ovf);
        end
    endtask

    task automatic test_cpu_write();
        do_reset();
        cpu_req = 1; cpu_we = 1; cpu_addr = 10'h3FF; cpu_wdata = 9'h1A5;
        @(negedge clk);
        idle_inputs();
        checks++;
        if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 10'h3FF, 9'h1A5}) begin
            errors++;
            $display("FAIL wr_issue: got en=%b we=%b addr=%h wdata=%h, expected 1 1 3ff 1a5",
                     ram_en, ram_we, ram_addr, ram_wdata);
        end
        @(negedge clk);
        checks++;
        if ({ram_en, cpu_done} !== 2'b00) begin
            errors++;
            $display("FAIL wr_n2: got en=%b done=%b, expected 0 0", ram_en, cpu_done);
        end
        @(negedge clk);
        checks++;
        if ({cpu_done, stall_cnt} !== {1'b1, 4'd0}) begin
            errors++;
            $display("FAIL wr_done: got done=%b stall=%0d, expected 1 0", cpu_done, stall_cnt);
        end
        @(negedge clk);
        checks++;
        if (cpu_done !== 1'b0) begin
            errors++;
            $display("FAIL wr_done_pulse: got done=%b, expected 0", cpu_done);
        end
    endtask

    task automatic test_cpu_read();
        cpu_write_drain(10'h010, 9'h155);
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h010;
        @(negedge clk);
        idle_inputs();
        checks++;
        if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, 10'h010}) begin
            errors++;
            $display("FAIL rd_issue: got en=%b we=%b addr=%h, expected 1 0 010", ram_en,
                     ram_we, ram_addr);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({cpu_done, cpu_rdata} !== {1'b1, 8'h55}) begin
            errors++;
            $display("FAIL rd_data: got done=%b rdata=%h, expected 1 55", cpu_done, cpu_rdata);
        end
    endtask

    task automatic test_simultaneous();
        cpu_write_drain(10'h220, 9'h1C3);
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h010; vid_req = 1; vid_addr = 9'h020;
        @(negedge clk);
        idle_inputs();
        checks++;
        if ({ram_en, ram_addr} !== {1'b1, 10'h010}) begin
            errors++;
            $display("FAIL sim_cpu_first: got en=%b addr=%h, expected 1 010", ram_en, ram_addr);
        end
        @(negedge clk);
        checks++;
        if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, 10'h220}) begin
            errors++;
            $display("FAIL sim_vid_second: got en=%b we=%b addr=%h, expected 1 0 220", ram_en,
                     ram_we, ram_addr);
        end
        @(negedge clk);
        checks++;
        if ({cpu_done, vid_ack, cpu_rdata} !== {1'b1, 1'b0, 8'h55}) begin
            errors++;
            $display("FAIL sim_cpu_done: got done=%b ack=%b rdata=%h, expected 1 0 55",
                     cpu_done, vid_ack, cpu_rdata);
        end
        @(negedge clk);
        checks++;
        if ({vid_ack, cpu_done, vid_rdata, stall_cnt} !== {1'b1, 1'b0, 9'h1C3, 4'd1}) begin
            errors++;
            $display("FAIL sim_vid_ack: got ack=%b done=%b vrd=%h stall=%0d, expected 1 0 1c3 1",
                     vid_ack, cpu_done, vid_rdata, stall_cnt);
        end
    endtask

    task automatic test_vid_overwrite();
        int acks;
        cpu_write_drain(10'h201, 9'h111);
        cpu_write_drain(10'h202, 9'h0AB);
        do_reset();
        acks = 0;
        for (int k = 0; k < 11; k++) begin
            if (vid_ack === 1'b1) acks++;
            if (k == 4) begin
                checks++;
                if ({ram_en, ram_addr} !== {1'b1, 10'h202}) begin
                    errors++;
                    $display("FAIL ovw_issue: got en=%b addr=%h, expected 1 202", ram_en,
                             ram_addr);
                end
            end
            cpu_req = (k < 3); cpu_we = 0; cpu_addr = 10'(k);
            vid_req = (k < 2); vid_addr = (k == 0) ? 9'h001 : 9'h002;
            @(negedge clk);
        end
        idle_inputs();
        checks++;
        if (acks !== 1) begin
            errors++;
            $display("FAIL ovw_ack_count: got %0d acks, expected 1", acks);
        end
        checks++;
        if (vid_rdata !== 9'h0AB) begin
            errors++;
            $display("FAIL ovw_data: got vrd=%h, expected 0ab", vid_rdata);
        end
    endtask

    task automatic test_starvation();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            if (k >= 1 && k <= 3) begin
                checks++;
                if ({ram_en, ram_addr} !== {1'b1, 10'(k - 1)}) begin
                    errors++;
                    $display("FAIL starve_cpu_c%0d: got en=%b addr=%h, expected 1 %h", k,
                             ram_en, ram_addr, 10'(k - 1));
                end
            end
            if (k == 4) begin
                checks++;
                if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, 10'h233}) begin
                    errors++;
                    $display("FAIL starve_vid_grant: got en=%b we=%b addr=%h, expected 1 0 233",
                             ram_en, ram_we, ram_addr);
                end
            end
            if (k == 7) begin
                checks++;
                if (cpu_ovf !== 1'b0) begin
                    errors++;
                    $display("FAIL starve_ovf_early: got ovf=%b, expected 0", cpu_ovf);
                end
            end
            cpu_req = 1; cpu_we = 0; cpu_addr = 10'(k);
            vid_req = 1; vid_addr = 9'h033;
            @(negedge clk);
        end
        idle_inputs();
        checks++;
        if ({cpu_ovf, ram_addr, stall_cnt} !== {1'b1, 10'h233, 4'd8}) begin
            errors++;
            $display("FAIL starve_ovf: got ovf=%b addr=%h stall=%0d, expected 1 233 8", cpu_ovf,
                     ram_addr, stall_cnt);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        int dones;
        checks++;
        if (cpu_ovf !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre_ovf: got ovf=%b, expected 1", cpu_ovf);
        end
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h010;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        reset_n = 0;
        #1;
        checks++;
        if ({cpu_rdata, cpu_done, cpu_ovf, vid_rdata, vid_ack, ram_en, ram_we, ram_addr,
             ram_wdata, stall_cnt} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: got en=%b addr=%h ovf=%b stall=%0d, expected all 0",
                     ram_en, ram_addr, cpu_ovf, stall_cnt);
        end
        @(negedge clk);
        reset_n = 1;
        dones = 0;
        repeat (6) begin
            @(negedge clk);
            if (cpu_done === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL midrst_no_done: got %0d dones, expected 0", dones);
        end
        checks++;
        if ({cpu_ovf, stall_cnt} !== '0) begin
            errors++;
            $display("FAIL midrst_state: got ovf=%b stall=%0d, expected 0 0", cpu_ovf,
                     stall_cnt);
        end
    endtask

    // ---------------- randomized traffic vs model ----------------
    task automatic test_random();
        logic [3:0] lo;
        logic       hi;
        do_reset();
        model_reset();
        for (int i = 0; i < 405; i++) begin
            checks++;
            if ({ram_en, ram_we} !== {e_en, e_we}) begin
                errors++;
                $display("FAIL rnd_en_we cyc %0d: got %b%b expected %b%b", mc_cyc, ram_en,
                         ram_we, e_en, e_we);
            end
            checks++;
            if ({ram_addr, ram_wdata} !== {e_addr, e_wdata}) begin
                errors++;
                $display("FAIL rnd_addr_wdata cyc %0d: got %h/%h expected %h/%h", mc_cyc,
                         ram_addr, ram_wdata, e_addr, e_wdata);
            end
            checks++;
            if ({cpu_done, vid_ack} !== {e_cdone, e_vack}) begin
                errors++;
                $display("FAIL rnd_done_ack cyc %0d: got %b%b expected %b%b", mc_cyc, cpu_done,
                         vid_ack, e_cdone, e_vack);
            end
            checks++;
            if ({cpu_ovf, stall_cnt} !== {m_ovf, m_stall[SW-1:0]}) begin
                errors++;
                $display("FAIL rnd_ovf_stall cyc %0d: got %b/%0d expected %b/%0d", mc_cyc,
                         cpu_ovf, stall_cnt, m_ovf, m_stall);
            end
            if (e_crd_ok) begin
                checks++;
                if (cpu_rdata !== e_crd) begin
                    errors++;
                    $display("FAIL rnd_cpu_rdata cyc %0d: got %h expected %h", mc_cyc,
                             cpu_rdata, e_crd);
                end
            end
            if (e_vrd_ok) begin
                checks++;
                if (vid_rdata !== e_vrd) begin
                    errors++;
                    $display("FAIL rnd_vid_rdata cyc %0d: got %h expected %h", mc_cyc,
                             vid_rdata, e_vrd);
                end
            end
            if (i < 400) begin
                lo = 4'($urandom_range(0, 15));
                hi = 1'($urandom_range(0, 1));
                cpu_req   = ($urandom_range(0, 9) < 5);
                cpu_we    = ($urandom_range(0, 2) == 0);
                cpu_addr  = {hi, 5'b0, lo};
                cpu_wdata = 9'($urandom_range(0, 511));
                lo = 4'($urandom_range(0, 15));
                vid_req   = ($urandom_range(0, 9) < 4);
                vid_addr  = {5'b0, lo};
            end else begin
                idle_inputs();
            end
            @(posedge clk);
            model_step();
            @(negedge clk);
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_cpu_write();
        test_cpu_read();
        test_simultaneous();
        test_vid_overwrite();
        test_starvation();
        test_reset_mid_op();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
